// File: rtl/rvh_pmp_chk_arb_pkg.sv
// Shared definitions for the PMP check arbiter: privilege levels, access types and
// the CSR-write sequencing states.
package rvh_pmp_chk_arb_pkg;

    localparam logic [1:0] PRIV_LVL_U = 2'b00;
    localparam logic [1:0] PRIV_LVL_S = 2'b01;
    localparam logic [1:0] PRIV_LVL_M = 2'b11;

    localparam logic [1:0] PMP_ACCESS_TYPE_R = 2'b00;
    localparam logic [1:0] PMP_ACCESS_TYPE_W = 2'b01;
    localparam logic [1:0] PMP_ACCESS_TYPE_X = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_WRITE = 2'b10
    } pmp_chk_arb_state_e;

endpackage

// File: rtl/rvh_pmp_chk_arb_if.sv
// Requester, PMP and CSR-write handshake bundle of the PMP check arbiter.
interface rvh_pmp_chk_arb_if #(
    parameter int REQ_COUNT   = 3,
    parameter int PADDR_WIDTH = 56
);
    logic [REQ_COUNT-1:0]             req_vld_i;
    logic [REQ_COUNT-1:0]             req_rdy_o;
    logic [REQ_COUNT*PADDR_WIDTH-1:0] req_paddr_i;
    logic [REQ_COUNT*2-1:0]           req_access_type_i;
    logic [REQ_COUNT*2-1:0]           req_priv_lvl_i;
    logic [REQ_COUNT-1:0]             resp_vld_o;
    logic                             resp_fail_o;
    logic                             pmp_chk_vld_o;
    logic [PADDR_WIDTH-1:0]           pmp_chk_paddr_o;
    logic [1:0]                       pmp_chk_access_type_o;
    logic [1:0]                       pmp_priv_lvl_o;
    logic                             pmp_chk_fail_i;
    logic                             csr_wr_req_i;
    logic                             csr_wr_gnt_o;

    modport slave (
        input  req_vld_i, req_paddr_i, req_access_type_i, req_priv_lvl_i,
               pmp_chk_fail_i, csr_wr_req_i,
        output req_rdy_o, resp_vld_o, resp_fail_o, pmp_chk_vld_o, pmp_chk_paddr_o,
               pmp_chk_access_type_o, pmp_priv_lvl_o, csr_wr_gnt_o
    );

    modport master (
        output req_vld_i, req_paddr_i, req_access_type_i, req_priv_lvl_i,
               pmp_chk_fail_i, csr_wr_req_i,
        input  req_rdy_o, resp_vld_o, resp_fail_o, pmp_chk_vld_o, pmp_chk_paddr_o,
               pmp_chk_access_type_o, pmp_priv_lvl_o, csr_wr_gnt_o
    );
endinterface

// File: rtl/rvh_rr_arbiter.sv
// Round-robin one-hot picker: search starts at the pointer, which moves past each winner.
module rvh_rr_arbiter #(
    parameter int REQ_COUNT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [REQ_COUNT-1:0] req,
    output logic [REQ_COUNT-1:0] gnt
);
    localparam int PTR_W = (REQ_COUNT > 1) ? $clog2(REQ_COUNT) : 1;

    logic [PTR_W-1:0] rr_ptr_r;
    logic [PTR_W-1:0] nxt_ptr_s;
    logic             found_s;

    // Scan requesters from the pointer with wrap-around; first active one wins
    always_comb begin
        int idx_v;
        idx_v     = 0;
        gnt       = {REQ_COUNT{1'b0}};
        nxt_ptr_s = rr_ptr_r;
        found_s   = 1'b0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            idx_v = int'(rr_ptr_r) + k;
            if (idx_v >= REQ_COUNT) begin
                idx_v = idx_v - REQ_COUNT;
            end else begin
                idx_v = idx_v;
            end
            if (en && !found_s && req[idx_v[PTR_W-1:0]]) begin
                found_s                 = 1'b1;
                gnt[idx_v[PTR_W-1:0]]   = 1'b1;
                if (idx_v == REQ_COUNT - 1) begin
                    nxt_ptr_s = {PTR_W{1'b0}};
                end else begin
                    nxt_ptr_s = PTR_W'(idx_v + 1);
                end
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer advances only on a grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= {PTR_W{1'b0}};
        end else if (found_s) begin
            rr_ptr_r <= nxt_ptr_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
endmodule

// File: rtl/rvh_pmp_chk_arb.sv
// Shares one combinational PMP among several requesters through a 2-stage non-stalling
// pipeline, and fences CSR writes so checks granted after the write see the new PMP state.
module rvh_pmp_chk_arb
    import rvh_pmp_chk_arb_pkg::*;
#(
    parameter int REQ_COUNT   = 3,
    parameter int PADDR_WIDTH = 56
) (
    input logic               clk,
    input logic               rst,
    rvh_pmp_chk_arb_if.slave  bus
);
    pmp_chk_arb_state_e       state_r;
    logic                     csr_wr_gnt_r;
    logic                     arb_en_s;
    logic [REQ_COUNT-1:0]     gnt_s;
    logic [PADDR_WIDTH-1:0]   sel_paddr_s;
    logic [1:0]               sel_access_s;
    logic [1:0]               sel_priv_s;
    logic                     s1_vld_r;
    logic [REQ_COUNT-1:0]     s1_owner_r;
    logic [PADDR_WIDTH-1:0]   s1_paddr_r;
    logic [1:0]               s1_access_r;
    logic [1:0]               s1_priv_r;
    logic [REQ_COUNT-1:0]     resp_vld_r;
    logic                     resp_fail_r;

    // Grants only in RUN with no pending CSR write; reset masks the combinational grant
    always_comb begin
        if ((state_r == ST_RUN) && !bus.csr_wr_req_i && !rst) begin
            arb_en_s = 1'b1;
        end else begin
            arb_en_s = 1'b0;
        end
    end

    rvh_rr_arbiter #(.REQ_COUNT(REQ_COUNT)) u_rr_arbiter (
        .clk (clk),
        .rst (rst),
        .en  (arb_en_s),
        .req (bus.req_vld_i),
        .gnt (gnt_s)
    );

    // One-hot payload select of the granted requester
    always_comb begin
        sel_paddr_s  = {PADDR_WIDTH{1'b0}};
        sel_access_s = 2'b00;
        sel_priv_s   = 2'b00;
        for (int i = 0; i < REQ_COUNT; i++) begin
            sel_paddr_s  = sel_paddr_s  | ({PADDR_WIDTH{gnt_s[i]}} & bus.req_paddr_i[i*PADDR_WIDTH +: PADDR_WIDTH]);
            sel_access_s = sel_access_s | ({2{gnt_s[i]}} & bus.req_access_type_i[i*2 +: 2]);
            sel_priv_s   = sel_priv_s   | ({2{gnt_s[i]}} & bus.req_priv_lvl_i[i*2 +: 2]);
        end
    end

    // S1 presents the accepted check to the PMP; S2 captures its verdict
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_r    <= 1'b0;
            s1_owner_r  <= {REQ_COUNT{1'b0}};
            s1_paddr_r  <= {PADDR_WIDTH{1'b0}};
            s1_access_r <= 2'b00;
            s1_priv_r   <= 2'b00;
            resp_vld_r  <= {REQ_COUNT{1'b0}};
            resp_fail_r <= 1'b0;
        end else begin
            s1_vld_r    <= |gnt_s;
            s1_owner_r  <= gnt_s;
            if (|gnt_s) begin
                s1_paddr_r  <= sel_paddr_s;
                s1_access_r <= sel_access_s;
                s1_priv_r   <= sel_priv_s;
            end else begin
                s1_paddr_r  <= s1_paddr_r;
                s1_access_r <= s1_access_r;
                s1_priv_r   <= s1_priv_r;
            end
            resp_vld_r  <= s1_owner_r;
            resp_fail_r <= s1_vld_r & bus.pmp_chk_fail_i;
        end
    end

    // CSR write fence: stop granting, let S1 empty, then a single-cycle write grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_RUN;
            csr_wr_gnt_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    csr_wr_gnt_r <= 1'b0;
                    state_r      <= bus.csr_wr_req_i ? ST_DRAIN : ST_RUN;
                end
                ST_DRAIN: begin
                    if (!bus.csr_wr_req_i) begin
                        state_r      <= ST_RUN;
                        csr_wr_gnt_r <= 1'b0;
                    end else if (!s1_vld_r) begin
                        state_r      <= ST_WRITE;
                        csr_wr_gnt_r <= 1'b1;
                    end else begin
                        state_r      <= ST_DRAIN;
                        csr_wr_gnt_r <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    state_r      <= ST_RUN;
                    csr_wr_gnt_r <= 1'b0;
                end
                default: begin
                    state_r      <= ST_RUN;
                    csr_wr_gnt_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_rdy_o             = gnt_s;
    assign bus.pmp_chk_vld_o         = s1_vld_r;
    assign bus.pmp_chk_paddr_o       = s1_paddr_r;
    assign bus.pmp_chk_access_type_o = s1_access_r;
    assign bus.pmp_priv_lvl_o        = s1_priv_r;
    assign bus.resp_vld_o            = resp_vld_r;
    assign bus.resp_fail_o           = resp_fail_r;
    assign bus.csr_wr_gnt_o          = csr_wr_gnt_r;
endmodule

// File: tb/tb_rvh_pmp_chk_arb.sv
// Directed bench for rvh_pmp_chk_arb with a one-region PMP model behind it.
module tb_rvh_pmp_chk_arb;
    import rvh_pmp_chk_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic region_on = 1'b0;
    logic pending_region = 1'b0;
    logic [55:0] s2_pa [3];

    rvh_pmp_chk_arb_if #(.REQ_COUNT(3), .PADDR_WIDTH(56)) bus ();

    rvh_pmp_chk_arb #(.REQ_COUNT(3), .PADDR_WIDTH(56)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // PMP model: once written, region [0x1000,0x2000) denies reads below M-mode
    assign bus.pmp_chk_fail_i = region_on && bus.pmp_chk_vld_o &&
                                (bus.pmp_chk_paddr_o[55:12] == 44'h1) &&
                                (bus.pmp_chk_access_type_o == PMP_ACCESS_TYPE_R) &&
                                (bus.pmp_priv_lvl_o != PRIV_LVL_M);

    // The pending CSR value lands in the PMP on the edge that ends the write-grant cycle
    always @(posedge clk) begin
        if (bus.csr_wr_gnt_o) region_on <= pending_region;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [55:0] pa, input logic [1:0] at, input logic [1:0] pl);
        bus.req_paddr_i[i*56 +: 56]     = pa;
        bus.req_access_type_i[i*2 +: 2] = at;
        bus.req_priv_lvl_i[i*2 +: 2]    = pl;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.req_vld_i = 3'b111;
        bus.req_paddr_i = {168{1'b0}};
        bus.req_access_type_i = 6'b0;
        bus.req_priv_lvl_i = 6'b0;
        bus.csr_wr_req_i = 1'b0;
        s2_pa[0] = 56'h0100_0000;
        s2_pa[1] = 56'h0200_0000;
        s2_pa[2] = 56'h0300_0000;
        step();
        step();
        chk("rst_rdy", bus.req_rdy_o, 64'h0);
        chk("rst_chk_vld", bus.pmp_chk_vld_o, 64'h0);
        chk("rst_resp_vld", bus.resp_vld_o, 64'h0);
        chk("rst_csr_gnt", bus.csr_wr_gnt_o, 64'h0);
        chk("rst_resp_fail", bus.resp_fail_o, 64'h0);
        chk("rst_paddr", bus.pmp_chk_paddr_o, 64'h0);
        bus.req_vld_i = 3'b000;
        rst = 1'b0;
        step();

        // Scenario 1: single check, latency 1 to PMP and 2 to response
        set_req(0, 56'h8000_0000, PMP_ACCESS_TYPE_R, PRIV_LVL_U);
        bus.req_vld_i = 3'b001;
        #1;
        chk("s1_rdy", bus.req_rdy_o, 64'h1);
        step();
        bus.req_vld_i = 3'b000;
        chk("s1_chk_vld", bus.pmp_chk_vld_o, 64'h1);
        chk("s1_paddr", bus.pmp_chk_paddr_o, 64'h8000_0000);
        chk("s1_priv", bus.pmp_priv_lvl_o, {62'h0, PRIV_LVL_U});
        chk("s1_resp_early", bus.resp_vld_o, 64'h0);
        step();
        chk("s1_resp_vld", bus.resp_vld_o, 64'h1);
        chk("s1_resp_fail", bus.resp_fail_o, 64'h0);
        chk("s1_chk_idle", bus.pmp_chk_vld_o, 64'h0);
        chk("s1_paddr_hold", bus.pmp_chk_paddr_o, 64'h8000_0000);

        // Scenario 5: reset with S1 and S2 both full (pointer is 1 here)
        set_req(1, 56'h3000_0000, PMP_ACCESS_TYPE_R, PRIV_LVL_S);
        bus.req_vld_i = 3'b011;
        #1;
        chk("s5_rdy_a", bus.req_rdy_o, 64'h2);
        step();
        chk("s5_rdy_b", bus.req_rdy_o, 64'h1);
        step();
        bus.req_vld_i = 3'b000;
        chk("s5_s2_busy", bus.resp_vld_o, 64'h2);
        chk("s5_s1_busy", bus.pmp_chk_vld_o, 64'h1);
        rst = 1'b1;
        #1;
        chk("s5_rst_chk_vld", bus.pmp_chk_vld_o, 64'h0);
        chk("s5_rst_resp_vld", bus.resp_vld_o, 64'h0);
        chk("s5_rst_paddr", bus.pmp_chk_paddr_o, 64'h0);
        chk("s5_rst_fail", bus.resp_fail_o, 64'h0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("s5_no_resp", bus.resp_vld_o, 64'h0);
        end

        // Scenario 2: all three requesting, round-robin from requester 0
        for (int i = 0; i < 3; i++) set_req(i, s2_pa[i], PMP_ACCESS_TYPE_W, PRIV_LVL_S);
        for (int k = 0; k < 8; k++) begin
            bus.req_vld_i = (k < 6) ? 3'b111 : 3'b000;
            #1;
            if (k < 6) chk("s2_rdy", bus.req_rdy_o, 64'h1 << (k % 3));
            step();
            chk("s2_chk_vld", bus.pmp_chk_vld_o, (k < 6) ? 64'h1 : 64'h0);
            if (k < 6) chk("s2_paddr", bus.pmp_chk_paddr_o, {8'h0, s2_pa[k % 3]});
            if (k >= 1 && k <= 6) chk("s2_resp", bus.resp_vld_o, 64'h1 << ((k - 1) % 3));
            else chk("s2_resp_idle", bus.resp_vld_o, 64'h0);
        end

        // Scenario 3: CSR write beats a simultaneous request while S1 is busy
        set_req(0, 56'h0400_0000, PMP_ACCESS_TYPE_R, PRIV_LVL_U);
        bus.req_vld_i = 3'b001;
        step();
        set_req(1, 56'h0500_0000, PMP_ACCESS_TYPE_W, PRIV_LVL_U);
        bus.req_vld_i = 3'b010;
        bus.csr_wr_req_i = 1'b1;
        #1;
        chk("s3_no_grant", bus.req_rdy_o, 64'h0);
        chk("s3_s1_busy", bus.pmp_chk_vld_o, 64'h1);
        step();
        chk("s3_drain_rdy", bus.req_rdy_o, 64'h0);
        chk("s3_drain_gnt", bus.csr_wr_gnt_o, 64'h0);
        chk("s3_inflight_resp", bus.resp_vld_o, 64'h1);
        chk("s3_inflight_fail", bus.resp_fail_o, 64'h0);
        step();
        chk("s3_write_gnt", bus.csr_wr_gnt_o, 64'h1);
        chk("s3_write_rdy", bus.req_rdy_o, 64'h0);
        bus.csr_wr_req_i = 1'b0;
        #1;
        chk("s3_write_rdy_nocsr", bus.req_rdy_o, 64'h0);
        step();
        chk("s3_gnt_pulse", bus.csr_wr_gnt_o, 64'h0);
        chk("s3_resume_rdy", bus.req_rdy_o, 64'h2);
        step();
        bus.req_vld_i = 3'b000;
        chk("s3_paddr", bus.pmp_chk_paddr_o, 64'h0500_0000);
        step();
        chk("s3_resp", bus.resp_vld_o, 64'h2);

        // Scenario 4: U-mode read of 0x1000 before the write passes
        set_req(2, 56'h0000_1000, PMP_ACCESS_TYPE_R, PRIV_LVL_U);
        bus.req_vld_i = 3'b100;
        #1;
        chk("s4_pre_rdy", bus.req_rdy_o, 64'h4);
        step();
        bus.req_vld_i = 3'b000;
        step();
        chk("s4_pre_resp", bus.resp_vld_o, 64'h4);
        chk("s4_pre_fail", bus.resp_fail_o, 64'h0);

        // Write request withdrawn during DRAIN: back to RUN without a write grant
        bus.csr_wr_req_i = 1'b1;
        step();
        bus.csr_wr_req_i = 1'b0;
        bus.req_vld_i = 3'b100;
        #1;
        chk("s4_drain_rdy", bus.req_rdy_o, 64'h0);
        step();
        chk("s4_abort_gnt", bus.csr_wr_gnt_o, 64'h0);
        chk("s4_abort_rdy", bus.req_rdy_o, 64'h4);
        step();
        bus.req_vld_i = 3'b000;
        step();
        chk("s4_abort_resp", bus.resp_vld_o, 64'h4);
        chk("s4_abort_fail", bus.resp_fail_o, 64'h0);

        // The real write: region covering 0x1000 with R=0
        pending_region = 1'b1;
        bus.csr_wr_req_i = 1'b1;
        step();
        chk("s4_w_drain_gnt", bus.csr_wr_gnt_o, 64'h0);
        step();
        chk("s4_w_gnt", bus.csr_wr_gnt_o, 64'h1);
        bus.csr_wr_req_i = 1'b0;
        step();
        bus.req_vld_i = 3'b100;
        #1;
        chk("s4_post_rdy", bus.req_rdy_o, 64'h4);
        step();
        bus.req_vld_i = 3'b000;
        step();
        chk("s4_post_resp", bus.resp_vld_o, 64'h4);
        chk("s4_post_fail", bus.resp_fail_o, 64'h1);

        set_req(2, 56'h0000_1000, PMP_ACCESS_TYPE_R, PRIV_LVL_M);
        bus.req_vld_i = 3'b100;
        step();
        bus.req_vld_i = 3'b000;
        step();
        chk("s4_m_resp", bus.resp_vld_o, 64'h4);
        chk("s4_m_fail", bus.resp_fail_o, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rvh_pmp_chk_arb.md
RVH_PMP_CHK_ARB -- requirements
Module: rvh_pmp_chk_arb

Interface
REQ-001 The block SHALL have parameter REQ_COUNT, default 3, meaning the number of check requesters (ITLB, DTLB, PTW).
REQ-002 The block SHALL have parameter PADDR_WIDTH, default 56, meaning the physical address width.
REQ-003 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit: the clock.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port req_vld_i, input, REQ_COUNT bits: per-requester check request.
REQ-007 The block SHALL have port req_rdy_o, output, REQ_COUNT bits: per-requester grant.
REQ-008 The block SHALL have port req_paddr_i, input, REQ_COUNT*PADDR_WIDTH bits: packed physical addresses.
REQ-009 The block SHALL have port req_access_type_i, input, REQ_COUNT*2 bits: packed access types.
REQ-010 The block SHALL have port req_priv_lvl_i, input, REQ_COUNT*2 bits: packed effective privilege levels.
REQ-011 The block SHALL have port resp_vld_o, output, REQ_COUNT bits: one-cycle response pulse to the owning requester.
REQ-012 The block SHALL have port resp_fail_o, output, 1 bit: check failure, qualified by resp_vld_o.
REQ-013 The block SHALL have ports pmp_chk_vld_o (1), pmp_chk_paddr_o (PADDR_WIDTH), pmp_chk_access_type_o (2), pmp_priv_lvl_o (2), all outputs, driving a PMP built with INPUT_REGISTER=0.
REQ-014 The block SHALL have port pmp_chk_fail_i, input, 1 bit: combinational PMP verdict for the current pmp_chk_* inputs.
REQ-015 The block SHALL have port csr_wr_req_i, input, 1 bit: a CSR pmpcfg/pmpaddr write is pending.
REQ-016 The block SHALL have port csr_wr_gnt_o, output, 1 bit: the write may be applied to the PMP this cycle.

Function
REQ-017 A request SHALL be accepted when req_vld_i[i] & req_rdy_o[i] is high; at most one req_rdy_o bit SHALL be high per cycle.
REQ-018 Arbitration SHALL be round-robin: search starts at the pointer rr_q; after a grant to i, rr_q becomes (i+1) mod REQ_COUNT; rr_q holds when no grant occurs.
REQ-019 An accepted request SHALL be registered into stage S1: pmp_chk_vld_o=1 in the next cycle, with paddr, access type, priv and requester id of the accepted request.
REQ-020 In S1, pmp_chk_fail_i SHALL be captured into stage S2; resp_vld_o[id]=1 and resp_fail_o=captured value one cycle later (accept-to-response latency exactly 2 cycles).
REQ-021 Throughput SHALL be one check per cycle; S1 and S2 SHALL never stall, and requesters SHALL always accept responses.
REQ-022 The FSM SHALL have states RUN, DRAIN and WRITE.
REQ-023 In RUN, with csr_wr_req_i=0, grants SHALL be issued normally.
REQ-024 In RUN, with csr_wr_req_i=1, the FSM SHALL go to DRAIN, and no grant SHALL be issued that cycle (write has priority over simultaneous requests).
REQ-025 In DRAIN, all req_rdy_o SHALL be 0; when S1 holds no valid request, the FSM SHALL go to WRITE.
REQ-026 S2 MAY still be valid when leaving DRAIN, because its verdict was already captured.
REQ-027 In WRITE, csr_wr_gnt_o SHALL be 1 for exactly one cycle, req_rdy_o SHALL be 0, and the FSM SHALL return to RUN.
REQ-028 In the cycle after WRITE, grants SHALL resume, so every check after the grant sees the new PMP state.
REQ-029 A check in flight before the grant SHALL complete with pre-write state.
REQ-030 If csr_wr_req_i drops in DRAIN, the FSM SHALL return to RUN with no grant.
REQ-031 When S1 is empty, pmp_chk_vld_o SHALL be 0.
REQ-032 pmp_chk_paddr_o, pmp_chk_access_type_o and pmp_priv_lvl_o SHALL hold their last values while pmp_chk_vld_o is 0 (payload enable = accept).

Reset
REQ-033 On rst the FSM SHALL enter RUN asynchronously and rr_q SHALL be 0.
REQ-034 On rst, S1 and S2 valid bits SHALL be 0, so that pmp_chk_vld_o=0, resp_vld_o=0, req_rdy_o=0 and csr_wr_gnt_o=0.
REQ-035 On rst, resp_fail_o SHALL be 0 and the payload registers SHALL be 0.
REQ-036 A reset mid-operation SHALL discard in-flight checks without a response.

Structure
REQ-037 The shared package SHALL hold the PRIV_LVL_M/S/U constants, the access-type encodings and the FSM state enum.
REQ-038 The round-robin picker SHALL be one sub-module, rvh_rr_arbiter, parameterised by REQ_COUNT.

Verification
REQ-039 Scenario 1: req_vld_i=3'b001, paddr=0x8000_0000, with PMP fail=0 -> pmp_chk_vld_o at T+1 and resp_vld_o=3'b001, resp_fail_o=0 at T+2.
REQ-040 Scenario 2: req_vld_i=3'b111 held for 6 cycles -> grant order 0,1,2,0,1,2 and one response per cycle to the matching id.
REQ-041 Scenario 3: csr_wr_req_i=1 together with req_vld_i=3'b010 while S1 is busy -> no grant, DRAIN for 1 cycle, csr_wr_gnt_o pulse, then requester 1 granted the next cycle.
REQ-042 Scenario 4: a write that makes pmpaddr0 cover 0x1000 with R=0, followed by a U-mode read of 0x1000 -> resp_fail_o=1; the same read issued before the write -> resp_fail_o=0.
REQ-043 Scenario 5: rst asserted with S1 and S2 both valid -> all outputs 0 immediately, no response after release, and the first grant goes to requester 0.
